uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the number of data bits per frame.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning a synchronous, active-high reset.
REQ-004 SHALL have port p_data  input  DATA_WIDTH  meaning the parallel word to transmit.
REQ-005 SHALL have port data_valid  input  1  meaning p_data is offered for transmission.
REQ-006 SHALL have port par_en  input  1  meaning 1 = a parity bit is inserted.
REQ-007 SHALL have port par_typ  input  1  meaning 0 = even parity, 1 = odd parity.
REQ-008 SHALL have port prescale  input  6  meaning the bit period in clk cycles; 0 is treated as 1.
REQ-009 SHALL have port tx_out  output  1  meaning the registered serial line, idle high.
REQ-010 SHALL have port busy  output  1  meaning a registered flag, 1 while a frame is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL accept a word only when in IDLE and data_valid=1 at a clk edge.
- At that edge it latches p_data, par_en, par_typ and prescale.
- It enters START.
REQ-013 SHALL ignore data_valid while busy=1; there is no buffering and no error flag.
REQ-014 SHALL hold each of START, each DATA bit, PARITY and STOP for exactly prescale_q cycles.
- Timing uses a 6-bit edge counter running 0..prescale_q-1; it wraps to 0 on each bit boundary.
REQ-015 SHALL drive tx_out as follows:
- START: 0.
- DATA: p_data_q[i], LSB first, i = 0..DATA_WIDTH-1, using a bit index counter.
- PARITY: ^p_data_q when par_typ_q=0; ~^p_data_q when par_typ_q=1.
- STOP: 1.
- IDLE: 1.
REQ-016 SHALL go from DATA to PARITY when par_en_q=1, and from DATA directly to STOP otherwise.
REQ-017 SHALL return from STOP to IDLE after the last STOP cycle.
- IDLE then lasts at least 1 cycle before the next START.
- Minimum inter-frame gap is 1 idle-high cycle.
REQ-018 SHALL register tx_out and busy.
- Both change on the edge after acceptance: tx_out=0, busy=1.
- busy=1 exactly while the state is not IDLE.
REQ-019 SHALL occupy exactly (2 + DATA_WIDTH + par_en_q) * prescale_q cycles with busy=1 per frame.
REQ-020 SHALL ignore changes to p_data, par_en, par_typ and prescale after acceptance until the frame ends.
REQ-021 SHALL accept a new word in the first IDLE cycle if data_valid is held high, giving back-to-back frames.

Reset
REQ-022 SHALL, when rst=1 at a clk edge, set the following at that edge, regardless of state:
- state = IDLE, tx_out = 1, busy = 0.
- edge counter, bit index and latched registers cleared to 0.
REQ-023 SHALL discard any frame in progress when reset is asserted mid-frame; no partial bits follow reset.
REQ-024 SHALL take priority for rst over data_valid in the same cycle; the word is not accepted.

Verification
REQ-025 SHALL be tested with prescale=8, p_data=8'hA5, par_en=1, par_typ=0, one data_valid pulse.
- tx_out: 0 | 1,0,1,0,0,1,0,1 | 0 | 1, each bit for 8 cycles.
- busy high for 88 cycles.
REQ-026 SHALL be tested with prescale=4, p_data=8'h01, par_en=1, par_typ=1.
- Parity bit = 0.
- Frame = 44 cycles.
REQ-027 SHALL be tested with prescale=1, p_data=8'hFF, par_en=0.
- tx_out: 0, then eight 1s, then 1 (stop).
- busy high for 10 cycles.
REQ-028 SHALL be tested with data_valid pulsed with p_data=8'h3C at cycle 20 of a frame with prescale=8.
- The pulse is ignored.
- The current frame is unchanged; no second frame follows.
REQ-029 SHALL be tested with data_valid held high, prescale=2, par_en=0.
- Consecutive frames are separated by exactly 1 idle-high cycle.
- Each frame is 20 cycles.
REQ-030 SHALL be tested with rst=1 for one cycle during the DATA state.
- Next cycle: tx_out=1 and busy=0.
- A subsequent data_valid starts a fresh, correct frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional even/odd parity, one stop.
// Each bit lasts prescale clk cycles (0 behaves as 1); tx_out and busy are registered.
module uart_tx #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic [5:0]            prescale,
   output logic                  tx_out,
   output logic                  busy
);

   localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   state_e                r_state;
   logic [5:0]            r_edge_cnt;
   logic [IdxW-1:0]       r_bit_idx;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_par_en;
   logic                  r_par_typ;
   logic [5:0]            r_prescale;
   logic                  r_tx;
   logic                  r_busy;

   state_e                w_state_next;
   logic [5:0]            w_edge_next;
   logic [IdxW-1:0]       w_bit_next;
   logic                  w_tx_next;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_parity;

   assign w_last   = (r_edge_cnt == r_prescale - 6'd1);
   assign w_parity = r_par_typ ? ~^r_data : ^r_data;

   always_comb begin
      w_state_next = r_state;
      w_bit_next   = r_bit_idx;
      w_edge_next  = '0;
      w_accept     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (data_valid) begin
               w_accept     = 1'b1;
               w_state_next = START;
            end
         end
         START: begin
            if (w_last) begin
               w_state_next = DATA;
               w_bit_next   = '0;
            end
         end
         DATA: begin
            if (w_last) begin
               if (r_bit_idx == IdxW'(DATA_WIDTH - 1)) begin
                  w_state_next = r_par_en ? PARITY : STOP;
               end else begin
                  w_bit_next = r_bit_idx + 1'b1;
               end
            end
         end
         PARITY: begin
            if (w_last) w_state_next = STOP;
         end
         STOP: begin
            if (w_last) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase

      // Edge counter wraps on every bit boundary and rests at 0 while idle.
      if ((r_state != IDLE) && !w_last) w_edge_next = r_edge_cnt + 6'd1;

      // Output is decoded from the next state so tx_out lines up with the state register.
      unique case (w_state_next)
         START:   w_tx_next = 1'b0;
         DATA:    w_tx_next = r_data[w_bit_next];
         PARITY:  w_tx_next = w_parity;
         default: w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_edge_cnt <= '0;
         r_bit_idx  <= '0;
         r_data     <= '0;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
         r_prescale <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_edge_cnt <= w_edge_next;
         r_bit_idx  <= w_bit_next;
         r_tx       <= w_tx_next;
         r_busy     <= (w_state_next != IDLE);
         if (w_accept) begin
            r_data     <= p_data;
            r_par_en   <= par_en;
            r_par_typ  <= par_typ;
            r_prescale <= (prescale == 6'd0) ? 6'd1 : prescale;
         end
      end
   end

   assign tx_out = r_tx;
   assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues hand-computed frames, a negedge monitor
// checks busy/tx_out cycle by cycle against the popped frame and flags unexpected frames.
module tb_uart_tx;

   logic       clk;
   logic       rst;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_en;
   logic       par_typ;
   logic [5:0] prescale;
   logic       tx_out;
   logic       busy;

   int n_pass  = 0;
   int n_total = 0;

   // bits[k] is the k-th line bit sent (start first); total = busy cycles before busy must drop.
   typedef struct {
      logic [15:0] bits;
      int          ps;
      int          total;
      int          gap;
      string       name;
   } frame_t;

   frame_t q[$];
   bit     mon_en = 0;
   bit     in_frame = 0;

   uart_tx #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .prescale   (prescale),
      .tx_out     (tx_out),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic push(input logic [15:0] bits, input int ps, input int total, input int gap,
                       input string name);
      frame_t f;
      f.bits  = bits;
      f.ps    = ps;
      f.total = total;
      f.gap   = gap;
      f.name  = name;
      q.push_back(f);
   endtask

   // Caller is at a negedge; returns at the negedge of frame cycle 0.
   task automatic offer(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
      p_data     = d;
      par_en     = pe;
      par_typ    = pt;
      prescale   = ps;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   // Monitor
   initial begin
      frame_t cur;
      int     cyc;
      int     idle_cnt;
      bit     rogue;
      idle_cnt = 0;
      rogue    = 0;
      cyc      = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (!in_frame) begin
               if (busy) begin
                  check("frame_expected", 32'(q.size() > 0), 32'd1);
                  in_frame = 1;
                  cyc      = 0;
                  if (q.size() > 0) begin
                     rogue = 0;
                     cur   = q.pop_front();
                     if (cur.gap >= 0) check({cur.name, "_gap"}, idle_cnt, cur.gap);
                  end else begin
                     rogue = 1;
                  end
               end else begin
                  idle_cnt++;
                  check("idle_tx_high", 32'(tx_out), 32'd1);
               end
            end
            if (in_frame) begin
               if (rogue) begin
                  if (!busy) begin
                     in_frame = 0;
                     idle_cnt = 1;
                  end
               end else if (cyc < cur.total) begin
                  check($sformatf("%s_c%0d", cur.name, cyc), {30'd0, busy, tx_out},
                        {30'd0, 1'b1, cur.bits[cyc / cur.ps]});
                  cyc++;
               end else begin
                  check({cur.name, "_end"}, {30'd0, busy, tx_out}, 32'd1);
                  in_frame = 0;
                  idle_cnt = 1;
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      rst        = 1'b1;
      p_data     = 8'h00;
      data_valid = 1'b0;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      prescale   = 6'd1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_tx", 32'(tx_out), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      mon_en = 1;
      repeat (2) @(negedge clk);

      // A5, even parity, prescale 8: 0 | 1,0,1,0,0,1,0,1 | 0 | 1
      push(16'b101_0100_1010, 8, 88, -1, "a5_even");
      offer(8'hA5, 1'b1, 1'b0, 6'd8);
      repeat (92) @(negedge clk);

      // FF, no parity, prescale 1: 0, eight 1s, stop
      push(16'b11_1111_1110, 1, 10, -1, "ff_nopar");
      offer(8'hFF, 1'b0, 1'b0, 6'd1);
      repeat (14) @(negedge clk);

      // prescale 0 behaves as 1
      push(16'b11_1111_1110, 1, 10, -1, "ps0");
      offer(8'hFF, 1'b0, 1'b0, 6'd0);
      repeat (14) @(negedge clk);

      // 96, no parity, prescale 8; mid-frame pulse of 3C with altered settings is ignored
      push(16'b11_0010_1100, 8, 80, -1, "96_ign");
      offer(8'h96, 1'b0, 1'b0, 6'd8);
      repeat (19) @(negedge clk);
      p_data     = 8'h3C;
      par_en     = 1'b1;
      par_typ    = 1'b1;
      prescale   = 6'd3;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (100) @(negedge clk);

      // C3 with data_valid held, prescale 2: two 20-cycle frames, 1 idle cycle between
      push(16'b11_1000_0110, 2, 20, -1, "c3_bb1");
      push(16'b11_1000_0110, 2, 20, 1, "c3_bb2");
      p_data     = 8'hC3;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      prescale   = 6'd2;
      data_valid = 1'b1;
      repeat (26) @(negedge clk);
      data_valid = 1'b0;
      repeat (40) @(negedge clk);

      // reset wins over data_valid in the same cycle
      p_data     = 8'h55;
      prescale   = 6'd1;
      rst        = 1'b1;
      data_valid = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      data_valid = 1'b0;
      repeat (20) @(negedge clk);

      // reset during DATA (bit 1 of A5 at prescale 4): frame cut after 10 busy cycles
      push(16'b101_0100_1010, 4, 10, -1, "abort");
      offer(8'hA5, 1'b1, 1'b0, 6'd4);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // fresh frame after reset: 01, odd parity (bit = 0), prescale 4, 44 cycles
      push(16'b100_0000_0010, 4, 44, -1, "01_odd");
      offer(8'h01, 1'b1, 1'b1, 6'd4);
      repeat (60) @(negedge clk);

      check("queue_drained", q.size(), 32'd0);
      check("frame_closed", 32'(in_frame), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
